// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and helpers for the chunked sequential adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2. Returns 0 for n <= 1, so callers clamp the result to at least 1 bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Operand and result handshake bundle for seq_chunk_adder.
// Defining ADD_SUB_EN adds the sub mode select.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef ADD_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
`ifdef ADD_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
`ifdef ADD_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/seq_chunk_adder_chunk_add.sv
// Combinational W-bit ripple slice built from full-adder cells.
// Also exposes the carry into its top bit for overflow detection.
module chunk_add #(
    parameter int W = 2
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb_in
);
    logic [W:0] c;

    assign c[0] = ci;

    for (genvar gi = 0; gi < W; gi++) begin : g_fa
        assign s[gi]    = x[gi] ^ y[gi] ^ c[gi];
        assign c[gi+1]  = (x[gi] & y[gi]) | (x[gi] & c[gi]) | (y[gi] & c[gi]);
    end

    assign co       = c[W];
    assign c_msb_in = c[W-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: sums CHUNK bits per clock with a registered carry between slices.
// Optional ADD_SUB_EN adds a subtract mode (a + ~b + 1).
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_chunk_adder_if.slave   bus
);
    localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
    localparam int CNT_W  = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    if ((CHUNK < 1) ? 1'b1 : ((WIDTH % CHUNK) != 0)) begin : g_param_err
        $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               carry_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               cout_reg;
    logic               ovf_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic [CHUNK-1:0]   sum_sl_reg [NCHUNK];

    logic [CHUNK-1:0]   a_sl [NCHUNK];
    logic [CHUNK-1:0]   b_sl [NCHUNK];
    logic [CHUNK-1:0]   slice_s;
    logic               slice_co;
    logic               slice_cmsb;
    logic [WIDTH-1:0]   b_eff;
    logic               c_eff;
    logic [WIDTH-1:0]   sum_w;

    // Subtraction is folded in at latch time so the datapath only ever adds.
`ifdef ADD_SUB_EN
    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign c_eff = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_eff = bus.b;
    assign c_eff = bus.cin;
`endif

    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
        assign a_sl[gi] = a_reg[gi*CHUNK +: CHUNK];
        assign b_sl[gi] = b_reg[gi*CHUNK +: CHUNK];
        assign sum_w[gi*CHUNK +: CHUNK] = sum_sl_reg[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_sl_reg[gi] <= '0;
            end else if (state_reg == BUSY && cnt_reg == CNT_W'(gi)) begin
                sum_sl_reg[gi] <= slice_s;
            end
        end
    end

    chunk_add #(
        .W (CHUNK)
    ) u_chunk_add (
        .x        (a_sl[cnt_reg]),
        .y        (b_sl[cnt_reg]),
        .ci       (carry_reg),
        .s        (slice_s),
        .co       (slice_co),
        .c_msb_in (slice_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            carry_reg     <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg        <= bus.a;
                        b_reg        <= b_eff;
                        carry_reg    <= c_eff;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= BUSY;
                    end
                end
                BUSY: begin
                    carry_reg <= slice_co;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        cout_reg      <= slice_co;
                        ovf_reg       <= slice_co ^ slice_cmsb;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    // Return to IDLE only; a new operand is taken on a later edge.
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_w;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed + random bench for seq_chunk_adder (CHUNK=2 and CHUNK=WIDTH instances).
// Build with ADD_SUB_EN defined to also exercise subtract mode.
module tb_seq_chunk_adder;
    localparam int WIDTH  = 8;
    localparam int NCHUNK = 4;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t sb8[$];

    seq_chunk_adder_if #(.WIDTH(WIDTH)) bus ();
    seq_chunk_adder_if #(.WIDTH(WIDTH)) bus8 ();

    seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic c, input logic s);
        exp_t       e;
        logic [7:0] be;
        logic       ce;
        logic [8:0] full;
        be     = s ? ~b : b;
        ce     = s ? 1'b1 : c;
        full   = {1'b0, a} + {1'b0, be} + {8'd0, ce};
        e.sum  = full[7:0];
        e.cout = full[8];
        e.ovf  = (a[7] == be[7]) && (full[7] != a[7]);
        return e;
    endfunction

    // One transaction on the CHUNK=2 instance, with optional stall in DONE.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic s, input int stall, input string tag);
        exp_t       e;
        exp_t       got;
        int         n;
        logic [7:0] held;
        sb.push_back(model(a, b, c, s));
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
`ifdef ADD_SUB_EN
        bus.sub      = s;
`endif
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " accept_wait"}, 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(NCHUNK));
        held = bus.sum;
        for (int i = 0; i < stall; i++) begin
            if (i == 1) begin
                bus.a        = 8'hAA;
                bus.b        = 8'h55;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check({tag, " stall_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, " stall_sum"}, 32'(bus.sum), 32'(held));
            check({tag, " stall_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        got.sum  = bus.sum;
        got.cout = bus.cout;
        got.ovf  = bus.ovf;
        check({tag, " sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " sum"}, 32'(got.sum), 32'(e.sum));
            check({tag, " cout"}, 32'(got.cout), 32'(e.cout));
            check({tag, " ovf"}, 32'(got.ovf), 32'(e.ovf));
            $display("op %s: a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d ovf=%0d",
                     tag, a, b, c, s, got.sum, got.cout, got.ovf);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, " release_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " release_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        exp_t e;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic       rs;
        int         idle_bad;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.in_valid = 1'b0;  bus.out_ready = 1'b0;
        bus.a = '0;  bus.b = '0;  bus.cin = 1'b0;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
        bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
`ifdef ADD_SUB_EN
        bus.sub = 1'b0;
        bus8.sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset sum", 32'(bus.sum), 32'd0);
        check("reset cout", 32'(bus.cout), 32'd0);
        check("reset ovf", 32'(bus.ovf), 32'd0);
        check("reset8 in_ready", 32'(bus8.in_ready), 32'd1);

        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, "t1_0f_01");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, "t2_ff_01");
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0, "t2_7f_01");
        run_op(8'h3C, 8'hA5, 1'b1, 1'b0, 0, "cin_3c_a5");

        // Stall in DONE with an in_valid pulse that must be dropped.
        run_op(8'h21, 8'h43, 1'b1, 1'b0, 5, "t3_stall");
        idle_bad = 0;
        for (int i = 0; i < NCHUNK + 2; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) idle_bad++;
        end
        check("t3 no_queued_op", 32'(idle_bad), 32'd0);

        // Reset during the second BUSY cycle.
        bus.a = 8'h99; bus.b = 8'h88; bus.cin = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("t4 busy_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t4 rst out_valid", 32'(bus.out_valid), 32'd0);
        check("t4 rst sum", 32'(bus.sum), 32'd0);
        check("t4 rst cout", 32'(bus.cout), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t4 post in_ready", 32'(bus.in_ready), 32'd1);
        check("t4 post out_valid", 32'(bus.out_valid), 32'd0);
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 0, "t4_12_34");

`ifdef ADD_SUB_EN
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 0, "t5_sub_05_07");
        run_op(8'h80, 8'h01, 1'b1, 1'b1, 0, "t5_sub_80_01");
`endif

        // Single-chunk instance: random ops, 1-cycle latency.
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
`ifdef ADD_SUB_EN
            rs = 1'($urandom_range(0, 1));
            bus8.sub = rs;
`else
            rs = 1'b0;
`endif
            sb8.push_back(model(ra, rb, rc, rs));
            bus8.a = ra; bus8.b = rb; bus8.cin = rc; bus8.in_valid = 1'b1;
            check("t6 in_ready", 32'(bus8.in_ready), 32'd1);
            @(posedge clk); #1;
            bus8.in_valid = 1'b0;
            check("t6 busy_valid", 32'(bus8.out_valid), 32'd0);
            @(posedge clk); #1;
            check("t6 latency1", 32'(bus8.out_valid), 32'd1);
            e = sb8.pop_front();
            check("t6 sum", 32'(bus8.sum), 32'(e.sum));
            check("t6 cout", 32'(bus8.cout), 32'(e.cout));
            check("t6 ovf", 32'(bus8.ovf), 32'(e.ovf));
            if (k < 4)
                $display("op t6_%0d: a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d ovf=%0d",
                         k, ra, rb, rc, rs, bus8.sum, bus8.cout, bus8.ovf);
            bus8.out_ready = 1'b1;
            @(posedge clk); #1;
            bus8.out_ready = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
